// File: rtl/matrix_pkg.sv
// Shared types and arithmetic for the matrix unite path: FSM state encoding,
// drain length and a width-generic saturating adder.
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} unite_state_t;

  localparam int DRAIN_CYCLES = 2;

  // Widest operand the adder supports; callers sign-extend into this and slice back.
  localparam int SAT_W = 64;

  // Returns {sat_flag, result}; result is clamped to the signed range of dw bits.
  function automatic logic [SAT_W:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      dw
  );
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] max_v;
    logic signed [SAT_W:0] min_v;
    one    = '0;
    one[0] = 1'b1;
    sum    = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    max_v  = (one <<< (dw - 1)) - one;
    min_v  = -(one <<< (dw - 1));
    if (sum > max_v)
      sat_add = {1'b1, max_v[SAT_W-1:0]};
    else if (sum < min_v)
      sat_add = {1'b1, min_v[SAT_W-1:0]};
    else
      sat_add = {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/unite_stage_sat_adder_reg.sv
// Registered saturating adder: one valid/address pair in, one result-RAM write out.
// Write data holds its last value while no write is issued.
module sat_adder_reg
  import matrix_pkg::*;
#(
  parameter int DW  = 32,
  parameter int BIT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [BIT-1:0]       in_addr,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic                 wr_en,
  output logic [BIT-1:0]       wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic                 sat
);

  logic [SAT_W:0]  sum_res;
  logic            wr_en_reg;
  logic [BIT-1:0]  wr_addr_reg;
  logic [DW-1:0]   wr_data_reg;
  logic            sat_reg;

  assign sum_res = sat_add(SAT_W'(a), SAT_W'(b), DW);

  generate
    if (DW < SAT_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^sum_res[SAT_W-1:DW];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      sat_reg     <= 1'b0;
    end else begin
      wr_en_reg <= in_valid;
      sat_reg   <= in_valid & sum_res[SAT_W];
      if (in_valid) begin
        wr_addr_reg <= in_addr;
        wr_data_reg <= sum_res[DW-1:0];
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign sat     = sat_reg;

endmodule

// File: rtl/unite_stage.sv
// Unite stage: on a start edge, streams CNT address pairs out of the partial RAMs,
// writes saturated sums to the result RAM, then raises rdy_out again.
module unite_stage
  import matrix_pkg::*;
#(
  parameter int CNT = 64,
  parameter int BIT = $clog2(CNT),
  parameter int DW  = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_in,
  output logic           rdy_out,
  output logic           rd_en_out,
  output logic [BIT-1:0] rd_addr_out,
  input  logic [DW-1:0]  a_data_in,
  input  logic [DW-1:0]  b_data_in,
  output logic           wr_en_out,
  output logic [BIT-1:0] wr_addr_out,
  output logic [DW-1:0]  wr_data_out,
  output logic           sat_out,
  output logic           busy_err_out
);

  unite_state_t   state_reg, state_next;
  logic           start_reg;
  logic           start_edge;
  logic           rdy_reg, rdy_next;
  logic           rd_en_reg, rd_en_next;
  logic [BIT-1:0] rd_addr_reg, rd_addr_next;
  logic [1:0]     drain_cnt_reg, drain_cnt_next;
  logic           sat_reg, sat_next;
  logic           busy_err_reg, busy_err_next;
  logic           rd_vld_reg;
  logic [BIT-1:0] rd_addr_d_reg;
  logic           add_wr_en;
  logic           add_sat;

  assign start_edge = start_in & ~start_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      start_reg     <= 1'b0;
      rdy_reg       <= 1'b1;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      drain_cnt_reg <= '0;
      sat_reg       <= 1'b0;
      busy_err_reg  <= 1'b0;
      rd_vld_reg    <= 1'b0;
      rd_addr_d_reg <= '0;
    end else begin
      state_reg     <= state_next;
      start_reg     <= start_in;
      rdy_reg       <= rdy_next;
      rd_en_reg     <= rd_en_next;
      rd_addr_reg   <= rd_addr_next;
      drain_cnt_reg <= drain_cnt_next;
      sat_reg       <= sat_next;
      busy_err_reg  <= busy_err_next;
      // Align the issued address with the RAM's one-cycle read latency.
      rd_vld_reg    <= rd_en_reg;
      rd_addr_d_reg <= rd_addr_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rdy_next       = rdy_reg;
    rd_en_next     = rd_en_reg;
    rd_addr_next   = rd_addr_reg;
    drain_cnt_next = drain_cnt_reg;
    sat_next       = sat_reg | (add_wr_en & add_sat);
    busy_err_next  = busy_err_reg;
    unique case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next    = READ;
          rd_en_next    = 1'b1;
          rd_addr_next  = '0;
          rdy_next      = 1'b0;
          sat_next      = 1'b0;
          busy_err_next = 1'b0;
        end
      end
      READ: begin
        if (rd_addr_reg == BIT'(CNT - 1)) begin
          state_next     = DRAIN;
          rd_en_next     = 1'b0;
          rd_addr_next   = '0;
          drain_cnt_next = '0;
        end else begin
          rd_addr_next = rd_addr_reg + BIT'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_reg == 2'(DRAIN_CYCLES - 1)) begin
          state_next = IDLE;
          rdy_next   = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Starts during a running job never restart it; they are only flagged.
    if (start_edge && (state_reg != IDLE))
      busy_err_next = 1'b1;
  end

  sat_adder_reg #(
    .DW  (DW),
    .BIT (BIT)
  ) u_adder (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_vld_reg),
    .in_addr  (rd_addr_d_reg),
    .a        (a_data_in),
    .b        (b_data_in),
    .wr_en    (add_wr_en),
    .wr_addr  (wr_addr_out),
    .wr_data  (wr_data_out),
    .sat      (add_sat)
  );

  assign wr_en_out    = add_wr_en;
  assign rdy_out      = rdy_reg;
  assign rd_en_out    = rd_en_reg;
  assign rd_addr_out  = rd_addr_reg;
  assign sat_out      = sat_reg;
  assign busy_err_out = busy_err_reg;

endmodule

// File: tb/tb_unite_stage.sv
// Scoreboard bench for unite_stage: jobs push expected writes, a negedge monitor
// pops and compares each result-RAM write; the job task checks timing and flags.
module tb_unite_stage;

  localparam int CNT = 64;
  localparam int BIT = 6;
  localparam int DW  = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start_in = 1'b0;
  logic           rdy_out, rd_en_out, wr_en_out, sat_out, busy_err_out;
  logic [BIT-1:0] rd_addr_out, wr_addr_out;
  logic [DW-1:0]  a_data_in, b_data_in, wr_data_out;

  logic [DW-1:0]  a_mem [CNT];
  logic [DW-1:0]  b_mem [CNT];

  typedef struct {
    logic [BIT-1:0] addr;
    logic [DW-1:0]  data;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  unite_stage #(.CNT(CNT), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_in     (start_in),
    .rdy_out      (rdy_out),
    .rd_en_out    (rd_en_out),
    .rd_addr_out  (rd_addr_out),
    .a_data_in    (a_data_in),
    .b_data_in    (b_data_in),
    .wr_en_out    (wr_en_out),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out),
    .sat_out      (sat_out),
    .busy_err_out (busy_err_out)
  );

  always #5 clk = ~clk;

  // Partial RAMs with registered read.
  always @(posedge clk) begin
    if (rd_en_out) begin
      a_data_in <= a_mem[rd_addr_out];
      b_data_in <= b_mem[rd_addr_out];
    end
  end

  function automatic logic [DW-1:0] ref_sat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic check(input logic [63:0] act, input logic [63:0] req, input string name);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && wr_en_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=addr %0d data %0h required=no write", wr_addr_out, wr_data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({wr_addr_out, wr_data_out}, {e.addr, e.data}, "write");
        $display("write addr=%0d data=%08h expected addr=%0d data=%08h", wr_addr_out, wr_data_out, e.addr, e.data);
      end
    end
  end

  task automatic fill(input int kind);
    for (int i = 0; i < CNT; i++) begin
      case (kind)
        0, 1: begin a_mem[i] = 32'(i); b_mem[i] = 32'(2 * i); end
        2:    begin a_mem[i] = 32'(i * 1000 - 5); b_mem[i] = 32'(-(7 * i)); end
        default: begin a_mem[i] = 32'h4000_0000 + 32'(i); b_mem[i] = 32'h3FFF_FFF0; end
      endcase
    end
    if (kind == 1) begin
      a_mem[5] = 32'h7FFF_FFFF; b_mem[5] = 32'h0000_0001;
      a_mem[9] = 32'h8000_0000; b_mem[9] = 32'hFFFF_FFFF;
    end
  endtask

  // Cycle c is the c-th negedge after the edge that samples the start pulse.
  task automatic run_job(input int busy_at, input int hold, input int abort_at,
                         input bit chain_in, input bit chain_out,
                         input bit exp_sat, input bit exp_busy);
    int first_wr, last_wr, n_wr, len;
    first_wr = -1; last_wr = -1; n_wr = 0;
    len = (hold + 2 > CNT + 3) ? hold + 2 : CNT + 3;
    if (chain_out) len = CNT + 2;
    for (int i = 0; i < CNT; i++)
      exp_q.push_back('{addr: BIT'(i), data: ref_sat(a_mem[i], b_mem[i])});
    if (!chain_in) @(negedge clk);
    start_in = 1'b1;
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      if (wr_en_out) begin
        n_wr++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      if (c == 0) begin
        check(64'(sat_out), 64'd0, "sat_cleared_at_start");
        check(64'(busy_err_out), 64'd0, "busy_cleared_at_start");
      end
      if (c < CNT) check({rd_en_out, rd_addr_out}, {1'b1, BIT'(c)}, "read_issue");
      if (c <= CNT + 1) check(64'(rdy_out), 64'd0, "rdy_low_during_job");
      else              check(64'(rdy_out), 64'd1, "rdy_high_after_job");
      if (c == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check({wr_en_out, rd_en_out, rdy_out}, {1'b0, 1'b0, 1'b1}, "async_reset_outputs");
        check(64'(wr_data_out), 64'd0, "async_reset_wr_data");
        $display("reset asserted mid-job at cycle %0d", c);
        @(negedge clk);
        reset = 1'b0;
        start_in = 1'b0;
        exp_q.delete();
        return;
      end
      if (c == hold - 1) start_in = 1'b0;
      if (c == busy_at) start_in = 1'b1;
      if (c == busy_at + 1) start_in = 1'b0;
    end
    check(64'(n_wr), 64'(CNT), "write_count");
    check(64'(first_wr), 64'd2, "first_write_cycle");
    check(64'(last_wr), 64'(CNT + 1), "last_write_cycle");
    check(64'(exp_q.size()), 64'd0, "expected_drained");
    check(64'(sat_out), 64'(exp_sat), "sat_after_job");
    check(64'(busy_err_out), 64'(exp_busy), "busy_err_after_job");
    $display("job done writes=%0d first=%0d last=%0d sat=%0b busy_err=%0b", n_wr, first_wr, last_wr, sat_out, busy_err_out);
    if (chain_out) start_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check({rdy_out, rd_en_out, wr_en_out, sat_out, busy_err_out}, 5'b10000, "reset_flags");
    check({rd_addr_out, wr_addr_out, wr_data_out}, '0, "reset_data");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    fill(0);  run_job(-10, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0);   // basic
    fill(1);  run_job(-10, 1, -1, 1'b0, 1'b0, 1'b1, 1'b0);   // saturation
    fill(2);  run_job(20, 1, -1, 1'b0, 1'b0, 1'b0, 1'b1);    // clean job, busy start
    fill(0);  run_job(-10, 200, -1, 1'b0, 1'b0, 1'b0, 1'b0); // held start
    fill(2);  run_job(-10, 1, 30, 1'b0, 1'b0, 1'b0, 1'b0);   // reset mid-job
    repeat (3) @(negedge clk);
    fill(0);  run_job(-10, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0);   // full job after reset
    // Controller model: next start is issued in the cycle rdy_out is seen high.
    fill(2);  run_job(-10, 1, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    fill(3);  run_job(-10, 1, -1, 1'b1, 1'b1, 1'b1, 1'b0);
    fill(0);  run_job(-10, 1, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
